// File: rtl/pmc_seq_pkg.sv
// Shared types and helpers for the pixel-matrix shift sequencer.
// Holds the state encoding, the data word width and the phase-timer sizing rule.
package pmc_seq_pkg;

    localparam int PMC_WORD_W = 64;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        GSETUP = 4'd1,
        LOAD   = 4'd2,
        SHA    = 4'd3,
        CLKH   = 4'd4,
        SHB    = 4'd5,
        STORE  = 4'd6,
        STROBE = 4'd7,
        DONE   = 4'd8
    } pmc_seq_state_t;

    // A divider of 1 still needs a one-bit counter.
    function automatic int pmc_timer_width(input int clk_div);
        int w;
        w = $clog2(clk_div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pmc_phase_timer.sv
// Loadable down-counter that times one shift phase.
// expired is high whenever the count has reached zero.
module pmc_phase_timer #(
    parameter int WIDTH    = 2,
    parameter int LOAD_VAL = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam logic [WIDTH-1:0] LOAD_V = WIDTH'(LOAD_VAL);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_V;
        end else if (count_q != '0) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/pmc_shift_sequencer.sv
// Drives one configuration/readout shift transaction onto the pixel-matrix control lines:
// gate setup, then per word LOAD/SHA/CLKH/SHB, then STORE/STROBE and a done pulse.
module pmc_shift_sequencer
    import pmc_seq_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int WORDS_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORDS_W-1:0]    word_cnt,
    input  logic                  wr_valid,
    input  logic [PMC_WORD_W-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  busy,
    output logic                  done,
    output logic [PMC_WORD_W-1:0] pm_din,
    output logic                  pm_gate,
    output logic                  pm_sh_a,
    output logic                  pm_clk_sh,
    output logic                  pm_sh_b,
    output logic                  pm_store,
    output logic                  pm_strobe,
    output logic [3:0]            dbg_state
);

    localparam int                 TIMER_W = pmc_timer_width(CLK_DIV);
    localparam logic [WORDS_W-1:0] ONE     = WORDS_W'(1);

    pmc_seq_state_t        state_q, state_d;
    logic [WORDS_W-1:0]    remaining_q, remaining_d;
    logic [PMC_WORD_W-1:0] din_q, din_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  sh_a_q, sh_a_d;
    logic                  clk_sh_q, clk_sh_d;
    logic                  sh_b_q, sh_b_d;
    logic                  store_q, store_d;
    logic                  strobe_q, strobe_d;
    logic                  accept;
    logic                  zero_done;
    logic                  timer_load;
    logic                  expired;

    pmc_phase_timer #(
        .WIDTH    (TIMER_W),
        .LOAD_VAL (CLK_DIV - 1)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .expired (expired)
    );

    // Stream handshake: a word transfers in exactly the cycle where wr_valid and
    // wr_ready are both high; the source holds wr_data stable while wr_valid is high.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        din_d       = din_q;
        accept      = 1'b0;
        zero_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_cnt != '0) begin
                        remaining_d = word_cnt;
                        state_d     = GSETUP;
                    end else begin
                        zero_done = 1'b1;
                    end
                end
            end
            GSETUP: if (expired) state_d = LOAD;
            LOAD: begin
                if (wr_valid && wr_ready_q) begin
                    accept  = 1'b1;
                    state_d = SHA;
                end
            end
            SHA:    if (expired) state_d = CLKH;
            CLKH:   if (expired) state_d = SHB;
            SHB:    if (expired) state_d = (remaining_q != '0) ? LOAD : STORE;
            STORE:  if (expired) state_d = STROBE;
            STROBE: if (expired) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A word handshaken in the same cycle as an abort is still consumed.
        if (accept) begin
            din_d = wr_data;
            if (remaining_q != '0) begin
                remaining_d = remaining_q - ONE;
            end
        end

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end

        // Timed states never loop on themselves, so any state change re-arms the timer.
        timer_load = (state_d != state_q);

        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE) || zero_done;
        wr_ready_d = (state_d == LOAD);
        sh_a_d     = (state_d == SHA);
        clk_sh_d   = (state_d == CLKH);
        sh_b_d     = (state_d == SHB);
        store_d    = (state_d == STORE);
        strobe_d   = (state_d == STROBE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            din_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ready_q  <= 1'b0;
            sh_a_q      <= 1'b0;
            clk_sh_q    <= 1'b0;
            sh_b_q      <= 1'b0;
            store_q     <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            din_q       <= din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_ready_q  <= wr_ready_d;
            sh_a_q      <= sh_a_d;
            clk_sh_q    <= clk_sh_d;
            sh_b_q      <= sh_b_d;
            store_q     <= store_d;
            strobe_q    <= strobe_d;
        end
    end

    assign wr_ready  = wr_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pm_din    = din_q;
    assign pm_gate   = busy_q;
    assign pm_sh_a   = sh_a_q;
    assign pm_clk_sh = clk_sh_q;
    assign pm_sh_b   = sh_b_q;
    assign pm_store  = store_q;
    assign pm_strobe = strobe_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pmc_shift_sequencer.sv
// Bench for pmc_shift_sequencer: a CLK_DIV=4 and a CLK_DIV=1 instance, each checked cycle by
// cycle against an expected waveform built from the transaction timeline.
module tb_pmc_shift_sequencer;

    localparam logic [8:0] F_BUSY = 9'h100;
    localparam logic [8:0] F_GATE = 9'h080;
    localparam logic [8:0] F_RDY  = 9'h040;
    localparam logic [8:0] F_SHA  = 9'h020;
    localparam logic [8:0] F_CLK  = 9'h010;
    localparam logic [8:0] F_SHB  = 9'h008;
    localparam logic [8:0] F_STO  = 9'h004;
    localparam logic [8:0] F_STB  = 9'h002;
    localparam logic [8:0] F_DONE = 9'h001;
    localparam logic [8:0] F_BG   = F_BUSY | F_GATE;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  start_r = '0;
    logic [1:0]  abort_r = '0;
    logic [1:0]  valid_r = '0;
    logic [7:0]  cnt_r  [2];
    logic [63:0] data_r [2];

    wire  [1:0]  ready_w, busy_w, done_w, gate_w, sha_w, clk_w, shb_w, store_w, strobe_w;
    wire  [63:0] din_w [2];
    wire  [3:0]  dbg_w [2];

    pmc_shift_sequencer #(.CLK_DIV(4), .WORDS_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start_r[0]), .abort(abort_r[0]), .word_cnt(cnt_r[0]),
        .wr_valid(valid_r[0]), .wr_data(data_r[0]), .wr_ready(ready_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .pm_din(din_w[0]), .pm_gate(gate_w[0]), .pm_sh_a(sha_w[0]),
        .pm_clk_sh(clk_w[0]), .pm_sh_b(shb_w[0]), .pm_store(store_w[0]), .pm_strobe(strobe_w[0]),
        .dbg_state(dbg_w[0])
    );

    pmc_shift_sequencer #(.CLK_DIV(1), .WORDS_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start_r[1]), .abort(abort_r[1]), .word_cnt(cnt_r[1]),
        .wr_valid(valid_r[1]), .wr_data(data_r[1]), .wr_ready(ready_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .pm_din(din_w[1]), .pm_gate(gate_w[1]), .pm_sh_a(sha_w[1]),
        .pm_clk_sh(clk_w[1]), .pm_sh_b(shb_w[1]), .pm_store(store_w[1]), .pm_strobe(strobe_w[1]),
        .dbg_state(dbg_w[1])
    );

    // scoreboard state
    logic [72:0] exp_q[$];
    logic [63:0] words_q[$];
    int          stalls_q[$];
    logic [63:0] din_model [2];
    int          errors = 0;
    int          checks = 0;
    int          store_idx;
    int          clkh1_idx;

    function automatic logic [72:0] obs(input int u);
        return {din_w[u], busy_w[u], gate_w[u], ready_w[u], sha_w[u], clk_w[u], shb_w[u],
                store_w[u], strobe_w[u], done_w[u]};
    endfunction

    task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_n(input int cnt, input logic [63:0] d, input logic [8:0] f);
        for (int i = 0; i < cnt; i++) exp_q.push_back({d, f});
    endtask

    // Expected waveform from the cycle after start, following the transaction timeline.
    task automatic build(input int u, input int c, input int n);
        logic [63:0] d;
        d = din_model[u];
        exp_q.delete();
        if (n == 0) begin
            push_n(1, d, F_DONE);
            push_n(2, d, 9'h000);
            return;
        end
        push_n(c, d, F_BG);
        for (int k = 0; k < n; k++) begin
            push_n(stalls_q[k] + 1, d, F_BG | F_RDY);
            d = words_q[k];
            push_n(c, d, F_BG | F_SHA);
            if (k == 0) clkh1_idx = exp_q.size() + 1;
            push_n(c, d, F_BG | F_CLK);
            push_n(c, d, F_BG | F_SHB);
        end
        store_idx = exp_q.size();
        push_n(c, d, F_BG | F_STO);
        push_n(c, d, F_BG | F_STB);
        push_n(1, d, F_BG | F_DONE);
        push_n(2, d, 9'h000);
    endtask

    // After an abort/reset in cycle 'at', everything drops the next cycle.
    task automatic cut_tail(input int at, input bit clr);
        logic [72:0] e;
        logic [63:0] d;
        e = exp_q[at];
        d = clr ? 64'h0 : e[72:9];
        while (exp_q.size() > at + 1) void'(exp_q.pop_back());
        push_n(3, d, 9'h000);
    endtask

    task automatic rst_pulse();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        din_model[0] = '0;
        din_model[1] = '0;
    endtask

    task automatic fill(input int n, input int stall_max);
        words_q.delete();
        stalls_q.delete();
        for (int i = 0; i < n; i++) begin
            words_q.push_back({$urandom, $urandom});
            stalls_q.push_back($urandom_range(0, stall_max));
        end
    endtask

    // Driver plus per-cycle comparison for one transaction on unit u.
    task automatic run_txn(input int u, input int c, input int n, input int abort_at,
                           input int rst_at, input bit restart, input string name);
        int k = 0, stall = 0, j = 0, busy_cyc = -1, done_cyc = -1, stall_tot = 0, restart_at = -1;
        bit hs, waitd, bad = 0;
        logic [72:0] e, g;
        build(u, c, n);
        for (int i = 0; i < n; i++) stall_tot += stalls_q[i];
        if (abort_at >= 0) cut_tail(abort_at, 1'b0);
        if (rst_at >= 0) cut_tail(rst_at, 1'b1);
        if (restart) restart_at = $urandom_range(0, exp_q.size() - 4);
        if (n > 0) stall = stalls_q[0];
        @(posedge clk); #1;
        start_r[u] = 1'b1;
        cnt_r[u]   = n[7:0];
        valid_r[u] = (n > 0) && (stall == 0);
        data_r[u]  = (n > 0) ? words_q[0] : {$urandom, $urandom};
        @(negedge clk);
        hs    = valid_r[u] & ready_w[u];
        waitd = ~valid_r[u] & ready_w[u];
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            start_r[u] = (j == restart_at);
            if (j == restart_at) cnt_r[u] = 8'($urandom_range(1, 255));
            abort_r[u] = (j == abort_at);
            rst        = (j == rst_at);
            if (hs) begin
                k++;
                stall = (k < n) ? stalls_q[k] : 0;
            end else if (waitd && stall > 0) begin
                stall--;
            end
            valid_r[u] = (k < n) && (stall == 0);
            data_r[u]  = (k < n) ? words_q[k] : {$urandom, $urandom};
            @(negedge clk);
            hs    = valid_r[u] & ready_w[u];
            waitd = ~valid_r[u] & ready_w[u];
            e = exp_q.pop_front();
            g = obs(u);
            if (g[8] && busy_cyc < 0) busy_cyc = j;
            if (g[0] && done_cyc < 0) done_cyc = j;
            if (!bad) begin
                check($sformatf("%s cyc%0d", name, j), g, e);
                check($sformatf("%s onehot cyc%0d", name, j), 73'($countones(g[5:1]) <= 1), 73'(1));
                if (g !== e) bad = 1'b1;
            end
            din_model[u] = e[72:9];
            j++;
        end
        start_r[u] = 1'b0;
        abort_r[u] = 1'b0;
        valid_r[u] = 1'b0;
        rst        = 1'b0;
        if (n > 0 && abort_at < 0 && rst_at < 0) begin
            check($sformatf("%s busy_rise", name), 73'(busy_cyc), 73'(0));
            check($sformatf("%s latency", name), 73'(done_cyc - busy_cyc),
                  73'(3 * c + n * (3 * c + 1) + stall_tot));
        end
        if (n == 0) check($sformatf("%s zero_busy", name), 73'(busy_cyc), 73'(-1));
        if (abort_at >= 0) check($sformatf("%s abort_nodone", name), 73'(done_cyc), 73'(-1));
        if (rst_at >= 0) begin
            din_model[0] = '0;
            din_model[1] = '0;
        end
        if (bad) rst_pulse();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cnt_r[0] = '0; cnt_r[1] = '0;
        data_r[0] = '0; data_r[1] = '0;
        din_model[0] = '0; din_model[1] = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset u0", obs(0), 73'(0));
        check("reset u1", obs(1), 73'(0));
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset u0", obs(0), 73'(0));

        // Directed: two words, valid held high.
        words_q = '{64'hA5A5_0000_0000_0001, 64'h0000_0000_0000_0002};
        stalls_q = '{0, 0};
        run_txn(0, 4, 2, -1, -1, 1'b0, "basic");

        // Directed: 10-cycle valid gap before word 2.
        words_q = '{64'hA5A5_0000_0000_0001, 64'h0000_0000_0000_0002};
        stalls_q = '{0, 10};
        run_txn(0, 4, 2, -1, -1, 1'b0, "stall10");

        // Zero word count.
        words_q.delete(); stalls_q.delete();
        run_txn(0, 4, 0, -1, -1, 1'b0, "zero");

        // Abort in the second CLKH cycle of word 1, then a normal transaction.
        fill(2, 0);
        build(0, 4, 2);
        run_txn(0, 4, 2, clkh1_idx, -1, 1'b0, "abort");
        fill(2, 1);
        run_txn(0, 4, 2, -1, -1, 1'b0, "after_abort");

        // Reset during STORE with a stray start mid-transaction.
        fill(2, 0);
        build(0, 4, 2);
        run_txn(0, 4, 2, -1, store_idx + 1, 1'b1, "rst_store");
        fill(1, 0);
        run_txn(0, 4, 1, -1, -1, 1'b0, "after_rst");

        for (int t = 0; t < 6; t++) begin
            fill($urandom_range(1, 4), 3);
            run_txn(0, 4, words_q.size(), -1, -1, 1'($urandom_range(0, 1)), $sformatf("rnd0_%0d", t));
        end

        // CLK_DIV=1 instance.
        fill(3, 0);
        run_txn(1, 1, 3, -1, -1, 1'b0, "div1_3");
        run_txn(1, 1, 0, -1, -1, 1'b0, "div1_zero");
        for (int t = 0; t < 6; t++) begin
            fill($urandom_range(1, 5), 3);
            run_txn(1, 1, words_q.size(), -1, -1, 1'($urandom_range(0, 1)), $sformatf("rnd1_%0d", t));
        end
        fill(255, 0);
        run_txn(1, 1, 255, -1, -1, 1'b0, "div1_max");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
